// File: rtl/uart_cmd_parser_if.sv
// Byte-stream input and register-command handshake between the UART side and
// the camera register master. The parser uses the master view.
interface uart_cmd_parser_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_we;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;

  modport master (
    input  rx_valid, rx_data, cmd_ready,
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata
  );

  modport slave (
    output rx_valid, rx_data, cmd_ready,
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte SOF/CMD/ADDR/DATA/CHK frames from the UART byte stream and
// issues valid ones as register read/write requests over valid/ready.
module uart_cmd_parser #(
  parameter logic [7:0]  SOF         = 8'hA5,
  parameter logic [7:0]  CMD_WR      = 8'h57,
  parameter logic [7:0]  CMD_RD      = 8'h52,
  parameter int unsigned TIMEOUT_MAX = 2_500_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  uart_cmd_parser_if.master     bus,
  output logic                  o_busy,
  output logic                  o_err_chk,
  output logic                  o_err_cmd,
  output logic                  o_err_timeout,
  output logic                  o_err_ovf
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_CMD  = 3'd1,
    GET_ADDR = 3'd2,
    GET_DATA = 3'd3,
    GET_CHK  = 3'd4,
    ISSUE    = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_cmd, w_cmd_nxt;
  logic [7:0]       r_addr, w_addr_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_cmd_valid, w_cmd_valid_nxt;
  logic             r_cmd_we, w_cmd_we_nxt;
  logic [7:0]       r_cmd_addr, w_cmd_addr_nxt;
  logic [7:0]       r_cmd_wdata, w_cmd_wdata_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_err_chk, w_err_chk_nxt;
  logic             r_err_cmd, w_err_cmd_nxt;
  logic             r_err_timeout, w_err_timeout_nxt;
  logic             r_err_ovf, w_err_ovf_nxt;
  logic             w_in_frame;
  logic             w_chk_ok;

  assign w_in_frame = (r_state == GET_CMD) || (r_state == GET_ADDR) ||
                      (r_state == GET_DATA) || (r_state == GET_CHK);
  assign w_chk_ok   = (bus.rx_data == (r_cmd ^ r_addr ^ r_data));

  // Next-state, shadow registers, command fields and error pulses
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = '0;
    w_cmd_nxt         = r_cmd;
    w_addr_nxt        = r_addr;
    w_data_nxt        = r_data;
    w_cmd_valid_nxt   = r_cmd_valid;
    w_cmd_we_nxt      = r_cmd_we;
    w_cmd_addr_nxt    = r_cmd_addr;
    w_cmd_wdata_nxt   = r_cmd_wdata;
    w_err_chk_nxt     = 1'b0;
    w_err_cmd_nxt     = 1'b0;
    w_err_timeout_nxt = 1'b0;
    w_err_ovf_nxt     = 1'b0;

    // A byte arriving on the limit cycle takes priority over the timeout
    if (w_in_frame && !bus.rx_valid) begin
      if (r_cnt == CNT_W'(TIMEOUT_MAX)) begin
        w_err_timeout_nxt = 1'b1;
        w_state_nxt       = IDLE;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end

    case (r_state)
      IDLE: begin
        if (bus.rx_valid && (bus.rx_data == SOF)) w_state_nxt = GET_CMD;
      end
      GET_CMD: begin
        if (bus.rx_valid) begin
          w_cmd_nxt = bus.rx_data;
          if ((bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD)) begin
            w_state_nxt = GET_ADDR;
          end else begin
            w_err_cmd_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end
        end
      end
      GET_ADDR: begin
        if (bus.rx_valid) begin
          w_addr_nxt  = bus.rx_data;
          w_state_nxt = GET_DATA;
        end
      end
      GET_DATA: begin
        if (bus.rx_valid) begin
          w_data_nxt  = bus.rx_data;
          w_state_nxt = GET_CHK;
        end
      end
      GET_CHK: begin
        if (bus.rx_valid) begin
          if (w_chk_ok) begin
            w_cmd_we_nxt    = (r_cmd == CMD_WR);
            w_cmd_addr_nxt  = r_addr;
            w_cmd_wdata_nxt = r_data;
            w_cmd_valid_nxt = 1'b1;
            w_state_nxt     = ISSUE;
          end else begin
            w_err_chk_nxt = 1'b1;
            w_state_nxt   = IDLE;
          end
        end
      end
      ISSUE: begin
        if (bus.rx_valid) w_err_ovf_nxt = 1'b1;
        if (r_cmd_valid && bus.cmd_ready) begin
          w_cmd_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_cmd         <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_cmd_valid   <= 1'b0;
      r_cmd_we      <= 1'b0;
      r_cmd_addr    <= '0;
      r_cmd_wdata   <= '0;
      r_busy        <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_cmd     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_ovf     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_cmd         <= w_cmd_nxt;
      r_addr        <= w_addr_nxt;
      r_data        <= w_data_nxt;
      r_cmd_valid   <= w_cmd_valid_nxt;
      r_cmd_we      <= w_cmd_we_nxt;
      r_cmd_addr    <= w_cmd_addr_nxt;
      r_cmd_wdata   <= w_cmd_wdata_nxt;
      r_busy        <= w_busy_nxt;
      r_err_chk     <= w_err_chk_nxt;
      r_err_cmd     <= w_err_cmd_nxt;
      r_err_timeout <= w_err_timeout_nxt;
      r_err_ovf     <= w_err_ovf_nxt;
    end
  end

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_we    = r_cmd_we;
  assign bus.cmd_addr  = r_cmd_addr;
  assign bus.cmd_wdata = r_cmd_wdata;
  assign o_busy        = r_busy;
  assign o_err_chk     = r_err_chk;
  assign o_err_cmd     = r_err_cmd;
  assign o_err_timeout = r_err_timeout;
  assign o_err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a short inter-byte timeout.
module tb_uart_cmd_parser;
  localparam int unsigned TO = 100;

  logic clk = 1'b0;
  logic rst;
  logic busy, e_chk, e_cmd, e_to, e_ovf;
  int   checks = 0;
  int   errors = 0;

  uart_cmd_parser_if bus();

  uart_cmd_parser #(.TIMEOUT_MAX(TO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus),
    .o_busy        (busy),
    .o_err_chk     (e_chk),
    .o_err_cmd     (e_cmd),
    .o_err_timeout (e_to),
    .o_err_ovf     (e_ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.cmd_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata, busy, e_chk, e_cmd, e_to, e_ovf} !== 23'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h exp 0", {bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata, busy, e_chk, e_cmd, e_to, e_ovf});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    bus.cmd_ready = 1'b1;
    send(8'hA5); send(8'h57); send(8'h12); send(8'h34); send(8'h71);
    checks++;
    if ({bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata, busy} !== {1'b1, 1'b1, 8'h12, 8'h34, 1'b1}) begin
      errors++;
      $display("FAIL write_issue: got %h exp %h", {bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata, busy}, {1'b1, 1'b1, 8'h12, 8'h34, 1'b1});
    end
    checks++;
    if ({e_chk, e_cmd, e_to, e_ovf} !== 4'b0) begin
      errors++; $display("FAIL write_no_err: got %b exp 0000", {e_chk, e_cmd, e_to, e_ovf});
    end
    tick();
    checks++;
    if ({bus.cmd_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL write_release: got %b exp 00", {bus.cmd_valid, busy});
    end
  endtask

  task automatic test_read_stall();
    bus.cmd_ready = 1'b0;
    send(8'hA5); send(8'h52); send(8'h0A); send(8'h00); send(8'h58);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata} !== {1'b1, 1'b0, 8'h0A, 8'h00}) begin
        errors++;
        $display("FAIL read_hold[%0d]: got %h exp %h", i, {bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata}, {1'b1, 1'b0, 8'h0A, 8'h00});
      end
      tick();
    end
    bus.cmd_ready = 1'b1;
    tick();
    checks++;
    if ({bus.cmd_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL read_release: got %b exp 00", {bus.cmd_valid, busy});
    end
  endtask

  task automatic test_bad_chk();
    logic [7:0] bad [2] = '{8'h27, 8'h26};
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(8'hA5); send(8'h57); send(8'h12); send(8'h34); send(bad[i]);
      checks++;
      if ({e_chk, bus.cmd_valid, busy} !== 3'b100) begin
        errors++; $display("FAIL bad_chk[%0d]: got %b exp 100", i, {e_chk, bus.cmd_valid, busy});
      end
      tick();
      checks++;
      if ({e_chk, bus.cmd_valid} !== 2'b00) begin
        errors++; $display("FAIL bad_chk_pulse[%0d]: got %b exp 00", i, {e_chk, bus.cmd_valid});
      end
    end
    send(8'hA5); send(8'h52); send(8'h33); send(8'h44); send(8'h25);
    checks++;
    if ({bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata} !== {1'b1, 1'b0, 8'h33, 8'h44}) begin
      errors++;
      $display("FAIL after_bad_chk: got %h exp %h", {bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata}, {1'b1, 1'b0, 8'h33, 8'h44});
    end
    tick();
  endtask

  task automatic test_bad_cmd();
    logic [7:0] tail [3] = '{8'h12, 8'h34, 8'h67};
    bus.cmd_ready = 1'b1;
    send(8'hA5); send(8'h41);
    checks++;
    if ({e_cmd, busy, bus.cmd_valid} !== 3'b100) begin
      errors++; $display("FAIL bad_cmd: got %b exp 100", {e_cmd, busy, bus.cmd_valid});
    end
    for (int i = 0; i < 3; i++) begin
      send(tail[i]);
      checks++;
      if ({bus.cmd_valid, busy, e_chk, e_cmd, e_to, e_ovf} !== 6'b0) begin
        errors++; $display("FAIL bad_cmd_tail[%0d]: got %b exp 000000", i, {bus.cmd_valid, busy, e_chk, e_cmd, e_to, e_ovf});
      end
    end
  endtask

  task automatic test_timeout();
    logic exp_to;
    bus.cmd_ready = 1'b1;
    send(8'hA5); send(8'h57);
    for (int k = 1; k <= TO + 2; k++) begin
      tick();
      exp_to = (k == TO + 1);
      checks++;
      if (e_to !== exp_to) begin
        errors++; $display("FAIL timeout_pulse[%0d]: got %b exp %b", k, e_to, exp_to);
      end
      if (k == TO) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL timeout_busy_before: got %b exp 1", busy);
        end
      end
    end
    checks++;
    if ({busy, bus.cmd_valid} !== 2'b00) begin
      errors++; $display("FAIL timeout_idle: got %b exp 00", {busy, bus.cmd_valid});
    end
    send(8'hA5); send(8'h57);
    for (int k = 0; k < TO; k++) tick();
    send(8'h12);
    checks++;
    if ({e_to, busy} !== 2'b01) begin
      errors++; $display("FAIL timeout_byte_wins: got %b exp 01", {e_to, busy});
    end
    send(8'h34); send(8'h71);
    checks++;
    if ({bus.cmd_valid, bus.cmd_addr, e_to} !== {1'b1, 8'h12, 1'b0}) begin
      errors++; $display("FAIL timeout_frame_ok: got %h exp %h", {bus.cmd_valid, bus.cmd_addr, e_to}, {1'b1, 8'h12, 1'b0});
    end
    tick();
  endtask

  task automatic test_overflow();
    bus.cmd_ready = 1'b0;
    send(8'hA5); send(8'h52); send(8'h0A); send(8'h00); send(8'h58);
    send(8'hA5);
    checks++;
    if ({e_ovf, bus.cmd_valid, busy} !== 3'b111) begin
      errors++; $display("FAIL ovf_sof: got %b exp 111", {e_ovf, bus.cmd_valid, busy});
    end
    tick();
    checks++;
    if ({e_ovf, bus.cmd_valid} !== 2'b01) begin
      errors++; $display("FAIL ovf_pulse: got %b exp 01", {e_ovf, bus.cmd_valid});
    end
    send(8'h52);
    checks++;
    if ({e_ovf, bus.cmd_valid, e_cmd} !== 3'b110) begin
      errors++; $display("FAIL ovf_second: got %b exp 110", {e_ovf, bus.cmd_valid, e_cmd});
    end
    bus.cmd_ready = 1'b1;
    send(8'hA5);
    checks++;
    if ({e_ovf, bus.cmd_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL ovf_handshake: got %b exp 100", {e_ovf, bus.cmd_valid, busy});
    end
    tick();
    send(8'hA5); send(8'h57); send(8'h12); send(8'h34); send(8'h71);
    checks++;
    if ({bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata} !== {1'b1, 1'b1, 8'h12, 8'h34}) begin
      errors++;
      $display("FAIL ovf_recover: got %h exp %h", {bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata}, {1'b1, 1'b1, 8'h12, 8'h34});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.cmd_ready = 1'b1;
    send(8'hA5); send(8'h57); send(8'h56); send(8'h78); send(8'h79);
    checks++;
    if ({bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata} !== {1'b1, 1'b1, 8'h56, 8'h78}) begin
      errors++;
      $display("FAIL b2b_first: got %h exp %h", {bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata}, {1'b1, 1'b1, 8'h56, 8'h78});
    end
    tick();
    send(8'hA5);
    checks++;
    if ({busy, e_ovf, bus.cmd_valid} !== 3'b100) begin
      errors++; $display("FAIL b2b_sof: got %b exp 100", {busy, e_ovf, bus.cmd_valid});
    end
    send(8'h52); send(8'h0A); send(8'h00); send(8'h58);
    checks++;
    if ({bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata} !== {1'b1, 1'b0, 8'h0A, 8'h00}) begin
      errors++;
      $display("FAIL b2b_second: got %h exp %h", {bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata}, {1'b1, 1'b0, 8'h0A, 8'h00});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.cmd_ready = 1'b1;
    send(8'hA5); send(8'h57); send(8'h12);
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata, busy, e_chk, e_cmd, e_to, e_ovf} !== 23'h0) begin
      errors++;
      $display("FAIL reset_mid: got %h exp 0", {bus.cmd_valid, bus.cmd_we, bus.cmd_addr, bus.cmd_wdata, busy, e_chk, e_cmd, e_to, e_ovf});
    end
    rst = 1'b0;
    send(8'h34); send(8'h71);
    checks++;
    if ({bus.cmd_valid, busy, e_chk, e_cmd, e_to, e_ovf} !== 6'b0) begin
      errors++; $display("FAIL reset_abort: got %b exp 000000", {bus.cmd_valid, busy, e_chk, e_cmd, e_to, e_ovf});
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stall();
    test_bad_chk();
    test_bad_cmd();
    test_timeout();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
